swc1_fetch_word_assembler: RTL and testbench

//  Ingress stage of the SWC1 RISC-V tile: turns the 8-bit byte stream from the

---
 rtl/swc1_fetch_word_assembler_if.sv | 33 +++
 rtl/swc1_fetch_word_assembler.sv | 95 +++++++++
 tb/tb_swc1_fetch_word_assembler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swc1_fetch_word_assembler_if.sv
`default_nettype none
// =============================================================================
// Module  : swc1_fetch_word_assembler_if
// Brief   : Byte-in / word-out handshake bundle for the SWC1 fetch assembler.
// Revision: 1.0
// =============================================================================
interface swc1_fetch_word_assembler_if #(
    parameter int DEPTH      = 4,
    parameter int WORD_BYTES = 4
);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;
    localparam int c_IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [8*WORD_BYTES-1:0]   out_data;
    logic [c_LVL_W-1:0]        level;
    logic [c_IDX_W-1:0]        byte_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, byte_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, byte_idx
    );
endinterface
`default_nettype wire

// File: rtl/swc1_fetch_word_assembler.sv
`default_nettype none
// =============================================================================
// Module  : swc1_fetch_word_assembler
// Brief   : Packs a little-endian byte stream into words and buffers them in a
//           first-word-fall-through FIFO with valid/ready on both sides.
// Revision: 1.0
// =============================================================================
module swc1_fetch_word_assembler #(
    parameter int DEPTH      = 4,
    parameter int WORD_BYTES = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clr,
    swc1_fetch_word_assembler_if.slave  bus
);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_DW    = 8 * WORD_BYTES;

    logic [c_IDX_W-1:0] r_byte_idx;
    logic [c_LVL_W-1:0] r_level;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_DW-1:0]    r_partial;
    logic [c_DW-1:0]    r_mem [DEPTH];

    logic               w_last;
    logic               w_out_valid;
    logic               w_pop;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_push;
    logic [c_DW-1:0]    w_word;

    assign w_last      = (r_byte_idx == c_IDX_W'(WORD_BYTES - 1));
    assign w_out_valid = (r_level != '0);
    assign w_pop       = w_out_valid & bus.out_ready & ~clr;
    // The final byte of a word may enter a full FIFO only when a pop frees a slot.
    assign w_in_ready  = ~rst & ~clr &
                         (~w_last | (r_level != c_LVL_W'(DEPTH)) | w_pop);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_push      = w_accept & w_last;

    always_comb begin
        w_word = r_partial;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (r_byte_idx == c_IDX_W'(k)) begin
                w_word[8*k +: 8] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_level    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_partial  <= '0;
        end else if (clr) begin
            r_byte_idx <= '0;
            r_level    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_partial  <= w_word;
                r_byte_idx <= w_last ? '0 : r_byte_idx + c_IDX_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
        end
    end

    // Storage keeps its contents across reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.level     = r_level;
    assign bus.byte_idx  = r_byte_idx;
endmodule
`default_nettype wire

// File: tb/tb_swc1_fetch_word_assembler.sv
`default_nettype none
// =============================================================================
// Module  : tb_swc1_fetch_word_assembler
// Brief   : Self-checking bench with a queue-based byte/word reference model.
// Revision: 1.0
// =============================================================================
module tb_swc1_fetch_word_assembler;
    localparam int c_DEPTH = 4;
    localparam int c_WB    = 4;

    logic clk;
    logic rst;
    logic clr;
    int   n_checks;
    int   n_errors;

    logic [7:0]  m_bytes [$];
    logic [31:0] m_fifo  [$];

    swc1_fetch_word_assembler_if #(.DEPTH(c_DEPTH), .WORD_BYTES(c_WB)) bus ();

    swc1_fetch_word_assembler #(.DEPTH(c_DEPTH), .WORD_BYTES(c_WB)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: a byte may enter unless it would complete a word while
    // the word FIFO is full and nothing is leaving.
    function automatic bit model_ready();
        if (rst || clr) return 1'b0;
        return (m_bytes.size() != c_WB - 1) || (m_fifo.size() < c_DEPTH) ||
               (m_fifo.size() != 0 && bus.out_ready);
    endfunction

    function automatic logic [31:0] model_head();
        return (m_fifo.size() != 0) ? m_fifo[0] : 32'h0;
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        m_fifo.delete();
    endtask

    task automatic tick();
        bit         acc;
        bit         pp;
        bit         flush;
        logic [7:0] d;
        acc   = bus.in_valid && model_ready();
        pp    = bus.out_ready && (m_fifo.size() != 0) && !clr;
        flush = clr;
        d     = bus.in_data;
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else begin
            if (pp) void'(m_fifo.pop_front());
            if (acc) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == c_WB) begin
                    m_fifo.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
                    m_bytes.delete();
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (c_DEPTH + 1) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        model_reset();
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            n_errors++; $display("FAIL reset_out: got valid=%b data=%h want 0/0", bus.out_valid, bus.out_data);
        end
        n_checks++;
        if (bus.level !== 3'd0 || bus.byte_idx !== 2'd0) begin
            n_errors++; $display("FAIL reset_counters: got level=%0d idx=%0d want 0/0", bus.level, bus.byte_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_word();
        logic [7:0] b [4];
        b[0] = 8'h13; b[1] = 8'h05; b[2] = 8'h00; b[3] = 8'h00;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = b[i];
            if (i == 3) begin
                #1;
                n_checks++;
                if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL first_latency: out_valid got %b want 0", bus.out_valid); end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0513 || bus.level !== 3'd1) begin
            n_errors++;
            $display("FAIL first_word: got valid=%b data=%h level=%0d want 1/00000513/1",
                     bus.out_valid, bus.out_data, bus.level);
        end
        drain();
    endtask

    task automatic test_full_backpressure();
        logic [7:0]  b [20];
        logic [31:0] w [5];
        for (int i = 0; i < 20; i++) b[i] = 8'($urandom);
        for (int k = 0; k < 5; k++) w[k] = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_data = b[i];
            tick();
        end
        n_checks++;
        if (bus.level !== 3'd4) begin n_errors++; $display("FAIL full_level: got %0d want 4", bus.level); end
        for (int i = 16; i < 19; i++) begin
            bus.in_data = b[i];
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL full_partial_ready byte %0d: got %b want 1", i, bus.in_ready); end
            tick();
        end
        bus.in_data = b[19];
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL full_last_blocked: got %b want 0", bus.in_ready); end
        tick();
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== w[0]) begin
            n_errors++; $display("FAIL full_pop_push: got ready=%b data=%h want 1/%h", bus.in_ready, bus.out_data, w[0]);
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.level !== 3'd4) begin n_errors++; $display("FAIL full_level_hold: got %0d want 4", bus.level); end
        for (int k = 1; k < 5; k++) begin
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== w[k]) begin
                n_errors++; $display("FAIL full_drain W%0d: got valid=%b data=%h want 1/%h", k, bus.out_valid, bus.out_data, w[k]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.level !== 3'd0) begin n_errors++; $display("FAIL full_empty: got level %0d want 0", bus.level); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b [40];
        logic [31:0] w [10];
        int          got;
        int          stalls;
        int          bad;
        for (int i = 0; i < 40; i++) b[i] = 8'($urandom);
        for (int k = 0; k < 10; k++) w[k] = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
        got = 0; stalls = 0; bad = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 46; i++) begin
            bus.in_valid = (i < 40);
            bus.in_data  = (i < 40) ? b[i] : 8'h00;
            #1;
            if (i < 40 && bus.in_ready !== 1'b1) stalls++;
            if (bus.out_valid === 1'b1) begin
                if (got >= 10 || bus.out_data !== w[got]) bad++;
                got++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (stalls != 0) begin n_errors++; $display("FAIL b2b_stall: got %0d stalls want 0", stalls); end
        n_checks++;
        if (got != 10 || bad != 0) begin n_errors++; $display("FAIL b2b_words: got %0d words (%0d wrong) want 10 (0 wrong)", got, bad); end
    endtask

    task automatic test_clear();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; tick();
        bus.in_data = 8'hBB; tick();
        bus.in_valid = 1'b0; clr = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL clr_in_ready: got %b want 0", bus.in_ready); end
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11; tick();
        bus.in_data = 8'h22; tick();
        bus.in_data = 8'h33; tick();
        bus.in_data = 8'h44; tick();
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_data !== 32'h44332211 || bus.level !== 3'd1 || bus.byte_idx !== 2'd0) begin
            n_errors++; $display("FAIL clr_word: got data=%h level=%0d idx=%0d want 44332211/1/0",
                                 bus.out_data, bus.level, bus.byte_idx);
        end
        drain();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.in_data = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.level !== 3'd3 || bus.byte_idx !== 2'd2) begin
            n_errors++; $display("FAIL areset_setup: got level=%0d idx=%0d want 3/2", bus.level, bus.byte_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.byte_idx !== 2'd0 || bus.out_data !== 32'h0) begin
            n_errors++; $display("FAIL areset_immediate: got valid=%b level=%0d idx=%0d data=%h want 0/0/0/0",
                                 bus.out_valid, bus.level, bus.byte_idx, bus.out_data);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int errs_before;
        int max_level;
        errs_before = n_errors;
        max_level = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 4);
            clr           = ($urandom_range(0, 499) == 0);
            #1;
            if (int'(bus.level) > max_level) max_level = int'(bus.level);
            n_checks++;
            if (bus.in_ready !== model_ready()) begin
                n_errors++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", c, bus.in_ready, model_ready());
            end
            n_checks++;
            if (bus.out_valid !== (m_fifo.size() != 0) || bus.out_data !== model_head()) begin
                n_errors++; $display("FAIL rand_out cyc %0d: got valid=%b data=%h want %b/%h",
                                     c, bus.out_valid, bus.out_data, m_fifo.size() != 0, model_head());
            end
            n_checks++;
            if (int'(bus.level) != m_fifo.size() || int'(bus.byte_idx) != m_bytes.size()) begin
                n_errors++; $display("FAIL rand_counters cyc %0d: got level=%0d idx=%0d want %0d/%0d",
                                     c, bus.level, bus.byte_idx, m_fifo.size(), m_bytes.size());
            end
            if (n_errors - errs_before > 20) break;
            tick();
        end
        clr = 1'b0;
        n_checks++;
        if (max_level > c_DEPTH) begin n_errors++; $display("FAIL rand_max_level: got %0d want <= %0d", max_level, c_DEPTH); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_first_word();
        test_full_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
